// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcode and funct
// field values, ALU control codes, the ALU-op class used between the FSM and
// the ALU decoder, and the FSM state encoding. The state numbering is exported
// on the debug port, so the values are fixed.
package mips_pkg;

  // Opcode field values
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  // R-type funct field values
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU control codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_OR    = 2'b11
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXE  = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXE   = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU control decoder for the multicycle controller (purely combinational).
// Ports:
//   aluop       in  ALU-op class chosen by the FSM (add / sub / by funct / or)
//   funct       in  R-type funct field
//   alucontrol  out 3-bit ALU operation code
//   funct_valid out 1 when funct is a supported R-type operation; only
//                   meaningful when aluop selects decode by funct
module mc_alu_decoder
  import mips_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [2:0]  alucontrol,
  output logic        funct_valid
);

  always_comb begin
    alucontrol  = ALU_ADD;
    funct_valid = 1'b1;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_OR:  alucontrol = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   funct_valid = 1'b0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit. Sequences fetch / decode / execute / memory /
// writeback over several cycles so the ALU, memory and register file are
// shared. Outputs are Moore decodes of the current state, except the strobes
// that complete a memory access (irwrite, pcen in FETCH; memwrite in MEMWR)
// and the branch pcen, which also look at mem_ready / zero.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   op, funct, zero     instruction fields and ALU zero flag
//   mem_ready           memory finishes the current access this cycle
//   mem_req, iord, memwrite, irwrite           memory side controls
//   regdst, memtoreg, regwrite                 register file controls
//   alusrca, alusrcb, zeroextend, alucontrol   ALU operand/op controls
//   pcsrc, pcen                                PC update controls
//   illegal_op          sticky trap flag, cleared only by reset
//   state               current FSM state (debug)
module multicycle_controller
  import mips_pkg::*;
#(
  parameter int ALUCTRL_W     = 3,
  parameter int SUPPORT_BNE   = 1,
  parameter int SUPPORT_ORI   = 1,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic                 zeroextend,
  output logic [1:0]           pcsrc,
  output logic                 pcen,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal_op,
  output logic [3:0]           state
);

  state_t     state_q, state_d;
  logic       illegal_op_q, illegal_op_d;
  aluop_t     aluop;
  logic [2:0] alu_ctrl3;
  logic       funct_valid;
  logic       mem_ok;
  logic       is_bne;
  logic       is_ori;

  // Without the handshake every memory access completes in its first cycle.
  assign mem_ok = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign is_bne = (SUPPORT_BNE != 0) && (op == OP_BNE);
  assign is_ori = (SUPPORT_ORI != 0) && (op == OP_ORI);

  mc_alu_decoder u_alu_dec (
    .aluop       (aluop),
    .funct       (funct),
    .alucontrol  (alu_ctrl3),
    .funct_valid (funct_valid)
  );

  always_comb begin
    alucontrol      = '0;
    alucontrol[2:0] = alu_ctrl3;
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    zeroextend = 1'b0;
    pcsrc      = 2'b00;
    pcen       = 1'b0;
    aluop      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        // PC+4 is computed every cycle, but IR and PC load only on completion.
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ok;
        pcen    = mem_ok;
        if (mem_ok) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut.
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_RTEXE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_BNE:       state_d = is_bne ? S_BRANCH : S_TRAP;
          OP_ADDI:      state_d = S_IEXE;
          OP_ORI:       state_d = is_ori ? S_IEXE : S_TRAP;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ok) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        // Strobe only in the completing cycle so the write happens once.
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = mem_ok;
        if (mem_ok) state_d = S_FETCH;
      end
      S_RTEXE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = funct_valid ? S_ALUWB : S_TRAP;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        pcen    = zero ^ is_bne;
        state_d = S_FETCH;
      end
      S_IEXE: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (is_ori) begin
          aluop      = ALUOP_OR;
          zeroextend = 1'b1;
        end
        state_d = S_IWB;
      end
      S_IWB: begin
        // Keep the IEXE operand controls so ALUOut-side paths stay consistent.
        regwrite = 1'b1;
        if (is_ori) begin
          aluop      = ALUOP_OR;
          zeroextend = 1'b1;
        end
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Flag rises together with the TRAP state so both are visible in one cycle.
  assign illegal_op_d = illegal_op_q | (state_d == S_TRAP);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_FETCH;
      illegal_op_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      illegal_op_q <= illegal_op_d;
    end
  end

  assign illegal_op = illegal_op_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. Two instances share the inputs: a fully
// featured one and a reduced one (no bne/ori, no memory handshake). Each
// instruction is expanded from its class into the list of states it must
// visit; every cycle the whole output vector is compared with the value the
// state-by-state control table predicts.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       m_mem_req, m_iord, m_memwrite, m_irwrite, m_regdst, m_memtoreg;
  logic       m_regwrite, m_alusrca, m_zeroextend, m_pcen, m_illegal_op;
  logic [1:0] m_alusrcb, m_pcsrc;
  logic [2:0] m_alucontrol;
  logic [3:0] m_state;

  logic       n_mem_req, n_iord, n_memwrite, n_irwrite, n_regdst, n_memtoreg;
  logic       n_regwrite, n_alusrca, n_zeroextend, n_pcen, n_illegal_op;
  logic [1:0] n_alusrcb, n_pcsrc;
  logic [2:0] n_alucontrol;
  logic [3:0] n_state;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(m_mem_req), .iord(m_iord),
    .memwrite(m_memwrite), .irwrite(m_irwrite), .regdst(m_regdst),
    .memtoreg(m_memtoreg), .regwrite(m_regwrite), .alusrca(m_alusrca),
    .alusrcb(m_alusrcb), .zeroextend(m_zeroextend), .pcsrc(m_pcsrc),
    .pcen(m_pcen), .alucontrol(m_alucontrol), .illegal_op(m_illegal_op),
    .state(m_state)
  );

  multicycle_controller #(
    .ALUCTRL_W(3), .SUPPORT_BNE(0), .SUPPORT_ORI(0), .MEM_HANDSHAKE(0)
  ) dut_min (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(n_mem_req), .iord(n_iord),
    .memwrite(n_memwrite), .irwrite(n_irwrite), .regdst(n_regdst),
    .memtoreg(n_memtoreg), .regwrite(n_regwrite), .alusrca(n_alusrca),
    .alusrcb(n_alusrcb), .zeroextend(n_zeroextend), .pcsrc(n_pcsrc),
    .pcen(n_pcen), .alucontrol(n_alucontrol), .illegal_op(n_illegal_op),
    .state(n_state)
  );

  // {state, mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
  //  alusrca, alusrcb, zeroextend, pcsrc, pcen, alucontrol, illegal_op}
  logic [21:0] vec_m, vec_n;
  assign vec_m = {m_state, m_mem_req, m_iord, m_memwrite, m_irwrite, m_regdst,
                  m_memtoreg, m_regwrite, m_alusrca, m_alusrcb, m_zeroextend,
                  m_pcsrc, m_pcen, m_alucontrol, m_illegal_op};
  assign vec_n = {n_state, n_mem_req, n_iord, n_memwrite, n_irwrite, n_regdst,
                  n_memtoreg, n_regwrite, n_alusrca, n_alusrcb, n_zeroextend,
                  n_pcsrc, n_pcen, n_alucontrol, n_illegal_op};

  int   n_cmp = 0;
  int   n_err = 0;
  logic sel = 1'b0;
  logic cfg_bne = 1'b1, cfg_ori = 1'b1, cfg_hs = 1'b1;

  task automatic chk(input string tag, input logic [21:0] obs, input logic [21:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
           (f == 6'b100101) || (f == 6'b101010);
  endfunction

  function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Control table: what each state drives, from the state's role.
  function automatic logic [21:0] exp_vec(input int s, input logic eff, input logic z,
                                          input logic [5:0] o, input logic [5:0] f);
    logic bne, ori, mreq, iord_e, mw, irw, rd, m2r, rw, asa, ze, pce, ill;
    logic [1:0] asb, psrc;
    logic [2:0] alu;
    bne = cfg_bne && (o == 6'b000101);
    ori = cfg_ori && (o == 6'b001101);
    mreq = (s == 0) || (s == 3) || (s == 5);
    iord_e = (s == 3) || (s == 5);
    mw  = (s == 5) && eff;
    irw = (s == 0) && eff;
    rd  = (s == 7);
    m2r = (s == 4);
    rw  = (s == 4) || (s == 7) || (s == 10);
    asa = (s == 2) || (s == 6) || (s == 8) || (s == 9);
    asb = (s == 0) ? 2'b01 : (s == 1) ? 2'b11 : (s == 2 || s == 9) ? 2'b10 : 2'b00;
    ze  = (s == 9 || s == 10) && ori;
    psrc = (s == 8) ? 2'b01 : (s == 11) ? 2'b10 : 2'b00;
    pce = (s == 0) ? eff : (s == 8) ? (z ^ bne) : (s == 11);
    alu = (s == 6) ? alu_of_funct(f) : (s == 8) ? 3'b110 : ze ? 3'b001 : 3'b010;
    ill = (s == 12);
    return {4'(s), mreq, iord_e, mw, irw, rd, m2r, rw, asa, asb, ze, psrc, pce, alu, ill};
  endfunction

  task automatic step(input int s, input logic r);
    logic eff;
    logic [21:0] e, o, mask;
    @(negedge clk);
    mem_ready = r;
    #1;
    eff  = cfg_hs ? r : 1'b1;
    e    = exp_vec(s, eff, zero, op, funct);
    mask = '1;
    if (s == 6 && !funct_ok(funct)) mask[3:1] = 3'b000;
    o = sel ? vec_n : vec_m;
    chk($sformatf("%s_st%0d_op%0h", sel ? "min" : "full", s, op), o & mask, e & mask);
  endtask

  task automatic do_reset();
    logic [21:0] o;
    @(negedge clk);
    reset_n = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    o = sel ? vec_n : vec_m;
    chk("reset_state", {o[21:18], o[15], o[11], o[0]}, 7'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic select_dut(input logic which);
    sel     = which;
    cfg_bne = !which;
    cfg_ori = !which;
    cfg_hs  = !which;
    do_reset();
  endtask

  // waits < 0: random mem_ready everywhere; otherwise fetch completes at
  // once and the data-memory access is held off for 'waits' cycles.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int waits);
    int seq[$];
    int n;
    logic r;
    op = o; funct = f; zero = z;
    case (o)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = funct_ok(f) ? '{0, 1, 6, 7} : '{0, 1, 6, 12};
      6'b000100: seq = '{0, 1, 8};
      6'b000101: seq = cfg_bne ? '{0, 1, 8} : '{0, 1, 12};
      6'b001000: seq = '{0, 1, 9, 10};
      6'b001101: seq = cfg_ori ? '{0, 1, 9, 10} : '{0, 1, 12};
      6'b000010: seq = '{0, 1, 11};
      default:   seq = '{0, 1, 12};
    endcase
    foreach (seq[i]) begin
      if (seq[i] == 0 || seq[i] == 3 || seq[i] == 5) begin
        n = 0;
        forever begin
          if (waits < 0) r = 1'($urandom_range(0, 1));
          else           r = (seq[i] == 0) ? 1'b1 : (n >= waits);
          if (n >= 8) r = 1'b1;
          step(seq[i], r);
          if (!cfg_hs || r) break;
          n++;
        end
      end else begin
        step(seq[i], 1'($urandom_range(0, 1)));
      end
    end
    if (seq[$] == 12) begin
      for (int k = 0; k < 20; k++) step(12, 1'(k % 2));
      do_reset();
    end
  endtask

  logic [5:0] ops_all [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                              6'b000101, 6'b001000, 6'b001101, 6'b000010};
  logic [5:0] functs  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  task automatic random_instrs(input int cnt, input int nops);
    logic [5:0] o, f;
    for (int k = 0; k < cnt; k++) begin
      o = ops_all[$urandom_range(0, nops - 1)];
      f = (o == 6'b000000) ? functs[$urandom_range(0, 4)] : 6'($urandom);
      run_instr(o, f, 1'($urandom_range(0, 1)), -1);
    end
  endtask

  initial begin
    select_dut(1'b0);
    // lw with three wait cycles in MEMRD
    run_instr(6'b100011, 6'd0, 1'b0, 3);
    // reset while stalled in MEMRD abandons the load
    op = 6'b100011;
    step(0, 1'b1); step(1, 1'b0); step(2, 1'b0); step(3, 1'b0); step(3, 1'b0);
    do_reset();
    step(0, 1'b0);
    // branches, ori, R-type, traps
    run_instr(6'b000100, 6'd0, 1'b1, -1);
    run_instr(6'b000101, 6'd0, 1'b1, -1);
    run_instr(6'b000101, 6'd0, 1'b0, -1);
    run_instr(6'b001101, 6'd0, 1'b0, 2);
    run_instr(6'b000000, 6'b100010, 1'b0, -1);
    run_instr(6'b000000, 6'b000000, 1'b0, -1);
    run_instr(6'b111111, 6'd0, 1'b0, -1);
    random_instrs(60, 8);

    select_dut(1'b1);
    run_instr(6'b101011, 6'd0, 1'b0, 5);
    run_instr(6'b100011, 6'd0, 1'b0, 5);
    run_instr(6'b000101, 6'd0, 1'b1, -1);
    run_instr(6'b001101, 6'd0, 1'b0, -1);
    random_instrs(30, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
